// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding and
// default bus widths / tuning values.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_MAX_D_STREAK   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_BUSY_I = BUSY_I,
    ST_BUSY_D = BUSY_D
  } arb_state_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable up-counter with a terminal-count flag; used as the bus-access
// timeout watchdog of the arbiter.
module mem_arb_timer #(
  parameter int               WIDTH    = 6,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;

  // Counter register: load has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TERMINAL);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the data stage.
// Data has priority; a streak counter bounds fetch starvation; a watchdog aborts hung accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_D_STREAK   = DEF_MAX_D_STREAK,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read_req,
  output logic              mem_write_req,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TIMER_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state_r, state_s;
  logic [STREAK_W-1:0] streak_r, streak_s;
  logic                grant_s, pulse_s, tc_s;

  logic              i_ready_r, i_ready_s, i_err_r, i_err_s;
  logic              d_ready_r, d_ready_s, d_err_r, d_err_s;
  logic [DATA_W-1:0] i_rdata_r, i_rdata_s, d_rdata_r, d_rdata_s;
  logic [ADDR_W-1:0] mem_address_r, mem_address_s;
  logic [DATA_W-1:0] mem_write_data_r, mem_write_data_s;
  logic              mem_read_req_r, mem_read_req_s, mem_write_req_r, mem_write_req_s;

  // The IDLE cycle carrying a completion pulse never grants, which enforces
  // one dead cycle between accesses and lets a requester hold req across it.
  assign pulse_s = i_ready_r | i_err_r | d_ready_r | d_err_r;

  mem_arb_timer #(
    .WIDTH    (TIMER_W),
    .TERMINAL (TIMER_W'(TIMEOUT_CYCLES - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (grant_s),
    .load_val ('0),
    .en       ((state_r != ST_IDLE) && !mem_ready),
    .tc       (tc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, grant, streak and next-output logic.
  always_comb begin
    state_s          = state_r;
    streak_s         = streak_r;
    grant_s          = 1'b0;
    i_ready_s        = 1'b0;
    i_err_s          = 1'b0;
    d_ready_s        = 1'b0;
    d_err_s          = 1'b0;
    i_rdata_s        = i_rdata_r;
    d_rdata_s        = d_rdata_r;
    mem_address_s    = mem_address_r;
    mem_write_data_s = mem_write_data_r;
    mem_read_req_s   = mem_read_req_r;
    mem_write_req_s  = mem_write_req_r;
    case (state_r)
      ST_IDLE: begin
        if (pulse_s) begin
          streak_s = i_req ? streak_r : '0;
        end else if (d_req && (!i_req || (streak_r != STREAK_MAX))) begin
          state_s          = ST_BUSY_D;
          grant_s          = 1'b1;
          mem_address_s    = d_addr;
          mem_write_data_s = d_wdata;
          mem_read_req_s   = !d_we;
          mem_write_req_s  = d_we;
          if (i_req) begin
            streak_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + STREAK_W'(1);
          end else begin
            streak_s = '0;
          end
        end else if (i_req) begin
          state_s         = ST_BUSY_I;
          grant_s         = 1'b1;
          mem_address_s   = i_addr;
          mem_read_req_s  = 1'b1;
          mem_write_req_s = 1'b0;
          streak_s        = '0;
        end else begin
          streak_s = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ready || tc_s) begin
          state_s         = ST_IDLE;
          mem_read_req_s  = 1'b0;
          mem_write_req_s = 1'b0;
          if (state_r == ST_BUSY_I) begin
            i_ready_s = mem_ready;
            i_err_s   = !mem_ready;
            i_rdata_s = mem_ready ? mem_read_data : i_rdata_r;
          end else begin
            d_ready_s = mem_ready;
            d_err_s   = !mem_ready;
            d_rdata_s = (mem_ready && mem_read_req_r) ? mem_read_data : d_rdata_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s         = ST_IDLE;
        mem_read_req_s  = 1'b0;
        mem_write_req_s = 1'b0;
      end
    endcase
  end

  // Output, data and streak registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_r         <= '0;
      i_ready_r        <= 1'b0;
      i_err_r          <= 1'b0;
      d_ready_r        <= 1'b0;
      d_err_r          <= 1'b0;
      i_rdata_r        <= '0;
      d_rdata_r        <= '0;
      mem_address_r    <= '0;
      mem_write_data_r <= '0;
      mem_read_req_r   <= 1'b0;
      mem_write_req_r  <= 1'b0;
    end else begin
      streak_r         <= streak_s;
      i_ready_r        <= i_ready_s;
      i_err_r          <= i_err_s;
      d_ready_r        <= d_ready_s;
      d_err_r          <= d_err_s;
      i_rdata_r        <= i_rdata_s;
      d_rdata_r        <= d_rdata_s;
      mem_address_r    <= mem_address_s;
      mem_write_data_r <= mem_write_data_s;
      mem_read_req_r   <= mem_read_req_s;
      mem_write_req_r  <= mem_write_req_s;
    end
  end

  assign i_ready        = i_ready_r;
  assign i_err          = i_err_r;
  assign i_rdata        = i_rdata_r;
  assign d_ready        = d_ready_r;
  assign d_err          = d_err_r;
  assign d_rdata        = d_rdata_r;
  assign mem_address    = mem_address_r;
  assign mem_write_data = mem_write_data_r;
  assign mem_read_req   = mem_read_req_r;
  assign mem_write_req  = mem_write_req_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with default parameters
// (MAX_D_STREAK=4, TIMEOUT_CYCLES=64).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_read_data;
  logic        i_ready, i_err, d_ready, d_err, mem_read_req, mem_write_req;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_read_data = 32'h0;
    tick(); tick();
    n_checks++; if ({i_ready, i_err, d_ready, d_err, mem_read_req, mem_write_req} !== 6'b0) begin n_fail++; $display("FAIL reset_strobes got=%b exp=000000", {i_ready, i_err, d_ready, d_err, mem_read_req, mem_write_req}); end
    n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    n_checks++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", mem_write_data); end
    n_checks++; if ({i_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata}); end
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    n_checks++; if ({mem_read_req, mem_write_req} !== 2'b10) begin n_fail++; $display("FAIL fetch_strobes got=%b exp=10", {mem_read_req, mem_write_req}); end
    n_checks++; if (mem_address !== 32'h100) begin n_fail++; $display("FAIL fetch_addr got=%h exp=00000100", mem_address); end
    mem_ready = 1'b1; mem_read_data = 32'h12345678;
    tick();
    n_checks++; if ({i_ready, i_rdata} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL fetch_ready got=%b/%h exp=1/12345678", i_ready, i_rdata); end
    n_checks++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL fetch_rreq_drop got=%b exp=0", mem_read_req); end
    i_req = 1'b0; mem_ready = 1'b0;
    tick();
    n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_len got=%b exp=0", i_ready); end
  endtask

  task automatic test_load_store();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    tick();
    mem_ready = 1'b1; mem_read_data = 32'hCAFEF00D;
    tick();
    n_checks++; if ({d_ready, d_rdata} !== {1'b1, 32'hCAFEF00D}) begin n_fail++; $display("FAIL load_ready got=%b/%h exp=1/cafef00d", d_ready, d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h89ABCDEF;
    tick();
    n_checks++; if ({mem_read_req, mem_write_req} !== 2'b01) begin n_fail++; $display("FAIL store_strobes got=%b exp=01", {mem_read_req, mem_write_req}); end
    n_checks++; if ({mem_address, mem_write_data} !== {32'h104, 32'h89ABCDEF}) begin n_fail++; $display("FAIL store_bus got=%h/%h exp=00000104/89abcdef", mem_address, mem_write_data); end
    mem_ready = 1'b1; mem_read_data = 32'h55555555;
    tick();
    n_checks++; if ({d_ready, mem_write_req} !== 2'b10) begin n_fail++; $display("FAIL store_ready got=%b exp=10", {d_ready, mem_write_req}); end
    n_checks++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL store_rdata_hold got=%h exp=cafef00d", d_rdata); end
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();
    n_checks++; if ({d_ready, mem_address} !== {1'b0, 32'h104}) begin n_fail++; $display("FAIL store_idle got=%b/%h exp=0/00000104", d_ready, mem_address); end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    tick();
    n_checks++; if ({mem_read_req, mem_address} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL simul_first got=%b/%h exp=1/00000400", mem_read_req, mem_address); end
    mem_ready = 1'b1; mem_read_data = 32'h11111111;
    tick();
    n_checks++; if ({d_ready, d_rdata, i_ready} !== {1'b1, 32'h11111111, 1'b0}) begin n_fail++; $display("FAIL simul_dready got=%b/%h/%b exp=1/11111111/0", d_ready, d_rdata, i_ready); end
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    n_checks++; if ({mem_read_req, mem_address} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL simul_second got=%b/%h exp=1/00000300", mem_read_req, mem_address); end
    mem_ready = 1'b1; mem_read_data = 32'h22222222;
    tick();
    n_checks++; if ({i_ready, i_rdata} !== {1'b1, 32'h22222222}) begin n_fail++; $display("FAIL simul_iready got=%b/%h exp=1/22222222", i_ready, i_rdata); end
    i_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int   d_first = 0, d_after = 0, f_cnt = 0;
    logic prev = 1'b0;
    i_req = 1'b1; i_addr = 32'h600; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int c = 0; c < 80 && f_cnt < 2; c++) begin
      tick();
      mem_ready = mem_read_req | mem_write_req;
      if ((mem_read_req | mem_write_req) && !prev) begin
        if (mem_address == 32'h600) f_cnt++;
        else if (f_cnt == 0) d_first++;
        else d_after++;
      end
      prev = mem_read_req | mem_write_req;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();
    n_checks++; if (f_cnt !== 2) begin n_fail++; $display("FAIL starve_fetches got=%0d exp=2", f_cnt); end
    n_checks++; if (d_first !== 4) begin n_fail++; $display("FAIL starve_streak1 got=%0d exp=4", d_first); end
    n_checks++; if (d_after !== 4) begin n_fail++; $display("FAIL starve_streak2 got=%0d exp=4", d_after); end
  endtask

  task automatic test_timeout();
    int   cyc = 0;
    logic seen_ready = 1'b0, early_drop = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; mem_ready = 1'b0;
    tick();
    n_checks++; if (mem_read_req !== 1'b1) begin n_fail++; $display("FAIL tmo_grant got=%b exp=1", mem_read_req); end
    while (!d_err && cyc < 100) begin
      tick();
      cyc++;
      if (d_ready) seen_ready = 1'b1;
      if (!d_err && !mem_read_req) early_drop = 1'b1;
    end
    n_checks++; if (cyc !== 64) begin n_fail++; $display("FAIL tmo_latency got=%0d exp=64", cyc); end
    n_checks++; if ({mem_read_req, seen_ready, early_drop} !== 3'b000) begin n_fail++; $display("FAIL tmo_flags got=%b exp=000", {mem_read_req, seen_ready, early_drop}); end
    d_req = 1'b0;
    tick();
    n_checks++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_len got=%b exp=0", d_err); end
    i_req = 1'b1; i_addr = 32'h800;
    tick();
    n_checks++; if ({mem_read_req, mem_address} !== {1'b1, 32'h800}) begin n_fail++; $display("FAIL tmo_fetch_grant got=%b/%h exp=1/00000800", mem_read_req, mem_address); end
    mem_ready = 1'b1; mem_read_data = 32'h33333333;
    tick();
    n_checks++; if ({i_ready, i_err, i_rdata} !== {2'b10, 32'h33333333}) begin n_fail++; $display("FAIL tmo_fetch_done got=%b%b/%h exp=10/33333333", i_ready, i_err, i_rdata); end
    i_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    logic seen_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h900;
    tick();
    n_checks++; if (mem_read_req !== 1'b1) begin n_fail++; $display("FAIL rbusy_grant got=%b exp=1", mem_read_req); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({mem_read_req, mem_address, d_rdata, i_rdata} !== {1'b0, 96'h0}) begin n_fail++; $display("FAIL rbusy_async got=%b/%h exp=0/0", mem_read_req, mem_address); end
    d_req = 1'b0; mem_ready = 1'b1; mem_read_data = 32'h99999999;
    tick();
    #3 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (d_ready || mem_read_req) seen_ready = 1'b1;
    end
    n_checks++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL rbusy_no_pulse got=%b exp=0", seen_ready); end
    mem_ready = 1'b0; d_req = 1'b1; d_addr = 32'h904;
    tick();
    n_checks++; if ({mem_read_req, mem_address} !== {1'b1, 32'h904}) begin n_fail++; $display("FAIL rbusy_regrant got=%b/%h exp=1/00000904", mem_read_req, mem_address); end
    mem_ready = 1'b1; mem_read_data = 32'h44444444;
    tick();
    n_checks++; if ({d_ready, d_rdata} !== {1'b1, 32'h44444444}) begin n_fail++; $display("FAIL rbusy_done got=%b/%h exp=1/44444444", d_ready, d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_store();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
